// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Accumulates a frame of up to BEATS unsigned operands (each with its own
//   carry-in) into one WIDTH-bit sum. The block has a valid/ready input for
//   operand beats. The result is held on a valid/ready output port until the
//   consumer accepts it. out_cout is sticky: it is set if any beat of the
//   frame carried out of bit WIDTH-1.
//
//   Optional feature macro: SATURATE_EN
//     defined   : the first carry-out of a frame forces the accumulator to
//                 all-ones, and it stays there for the rest of the frame.
//     undefined : the sum wraps modulo 2^WIDTH.
//
//   Ports
//     clk, rst_n            clock, async active-low reset
//     in_valid/in_ready     operand beat handshake
//     in_data, in_cin       operand and its carry-in
//     in_last               early end of frame
//     out_valid/out_ready   result handshake
//     out_sum, out_cout     accumulated sum, sticky carry-out
//     out_count             beats accumulated in the frame
module sum_accumulator #(
  parameter  int WIDTH = 32,
  parameter  int BEATS = 4,
  localparam int CNT_W = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             first;
  logic [WIDTH-1:0] base;
  logic             cout_base;
  logic [WIDTH:0]   sum_w;
  logic             cout_new;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frame_end;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = acc_q;
  assign out_cout  = cout_q;
  assign out_count = cnt_q;

  assign accept = in_valid && in_ready;

  // The first beat of a frame starts from zero. This way the result of the
  // previous frame stays visible on the outputs until the next beat lands.
  assign first     = (state_q == S_IDLE);
  assign base      = first ? '0 : acc_q;
  assign cout_base = first ? 1'b0 : cout_q;

  assign sum_w     = {1'b0, base} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};
  assign cout_new  = cout_base | sum_w[WIDTH];
  assign cnt_nxt   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  // Reaching BEATS ends the frame whether or not in_last is set.
  // With BEATS==1 the first beat always ends the frame.
  assign frame_end = in_last || (cnt_nxt == CNT_W'(BEATS));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
`ifdef SATURATE_EN
          // Once a carry has been seen, keep the accumulator pinned at
          // all-ones, even if later beats do not overflow again.
          acc_d = cout_new ? '1 : sum_w[WIDTH-1:0];
`else
          acc_d = sum_w[WIDTH-1:0];
`endif
          cout_d  = cout_new;
          cnt_d   = cnt_nxt;
          state_d = frame_end ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;
  localparam int WIDTH = 32;
  localparam int BEATS = 4;
  localparam int CNT_W = $clog2(BEATS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_cin = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_count(out_count)
  );

  typedef struct {
    logic [3:0][31:0] d;
    logic [3:0]       cin;
    int               n;
    logic             last;
    logic [31:0]      esum;
    logic             ecout;
    int               ecnt;
  } vec_t;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                              logic [31:0] e, logic [3:0] cin, int n, logic l,
                              logic [31:0] s, logic co, int cnt);
    vec_t v;
    v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
    v.cin = cin; v.n = n; v.last = l; v.esum = s; v.ecout = co; v.ecnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are driven #1 after a rising edge. in_ready is sampled at that
  // same point, and the beat is accepted on the next rising edge.
  task automatic drive_beat(input logic [31:0] d, input logic c, input logic l, input int gap);
    int to;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_cin = c; in_last = l;
    to = 0;
    while (!in_ready && to < 50) begin @(posedge clk); #1; to++; end
    if (to >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ack_valid_drop", 64'(out_valid), 64'd0);
    chk("ack_ready_back", 64'(in_ready), 64'd1);
  endtask

  task automatic run_frame(input string nm, input logic [3:0][31:0] d, input logic [3:0] cin,
                           input int n, input logic uselast, input int gap, input int stall,
                           input logic [31:0] esum, input logic ecout, input int ecnt);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) chk({nm, "_valid_pre"}, 64'(out_valid), 64'd0);
      drive_beat(d[i], cin[i], uselast && (i == n - 1), gap);
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_sum"},   64'(out_sum),   64'(esum));
    chk({nm, "_cout"},  64'(out_cout),  64'(ecout));
    chk({nm, "_count"}, 64'(out_count), 64'(ecnt));
    repeat (stall) begin @(posedge clk); #1; end
    chk({nm, "_sum_held"}, 64'(out_sum), 64'(esum));
    ack();
  endtask

  vec_t tbl[8];

  initial begin
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    tbl[0] = mk(1, 2, 3, 4, 4'h0, 4, 1'b0, 32'd10, 1'b0, 4);
`ifdef SATURATE_EN
    tbl[1] = mk(ones, 1, 0, 0, 4'h0, 4, 1'b0, ones, 1'b1, 4);
    tbl[5] = mk(32'h8000_0000, 32'h8000_0000, 3, 0, 4'h0, 4, 1'b0, ones, 1'b1, 4);
    tbl[6] = mk(ones, 0, 0, 0, 4'h1, 1, 1'b1, ones, 1'b1, 1);
`else
    tbl[1] = mk(ones, 1, 0, 0, 4'h0, 4, 1'b0, 32'd0, 1'b1, 4);
    tbl[5] = mk(32'h8000_0000, 32'h8000_0000, 3, 0, 4'h0, 4, 1'b0, 32'd3, 1'b1, 4);
    tbl[6] = mk(ones, 0, 0, 0, 4'h1, 1, 1'b1, 32'd0, 1'b1, 1);
`endif
    tbl[2] = mk(5, 7, 0, 0, 4'h0, 2, 1'b1, 32'd12, 1'b0, 2);
    tbl[3] = mk(42, 0, 0, 0, 4'h1, 1, 1'b1, 32'd43, 1'b0, 1);
    tbl[4] = mk(10, 20, 30, 40, 4'h0, 4, 1'b1, 32'd100, 1'b0, 4);
    tbl[7] = mk(32'hFFFF_FFFE, 0, 0, 0, 4'h2, 2, 1'b1, ones, 1'b0, 2);

    // Reset values
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_sum",   64'(out_sum),   64'd0);
    chk("rst_cout",  64'(out_cout),  64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].cin, tbl[i].n, tbl[i].last,
                0, 0, tbl[i].esum, tbl[i].ecout, tbl[i].ecnt);

    // Gaps between beats: the partial state must hold across idle cycles
    begin
      for (int i = 0; i < 4; i++) begin
        drive_beat(32'd0, 1'b1, 1'b0, 0);
        if (i < 3) begin
          repeat (2) begin @(posedge clk); #1; end
          chk("gap_count", 64'(out_count), 64'(i + 1));
          chk("gap_sum",   64'(out_sum),   64'(i + 1));
        end
      end
      chk("gap_valid", 64'(out_valid), 64'd1);
      chk("gap_final_sum", 64'(out_sum), 64'd4);
      chk("gap_final_count", 64'(out_count), 64'd4);
      ack();
    end

    // Back-pressure in DONE, with a new beat already waiting at the input
    begin
      drive_beat(32'd1, 1'b0, 1'b0, 0);
      drive_beat(32'd2, 1'b0, 1'b1, 0);
      in_valid = 1'b1; in_data = 32'd100; in_cin = 1'b0; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_ready", 64'(in_ready),  64'd0);
        chk("bp_sum",   64'(out_sum),   64'd3);
        chk("bp_count", 64'(out_count), 64'd2);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_hs_valid", 64'(out_valid), 64'd0);
      chk("bp_hs_ready", 64'(in_ready),  64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_count", 64'(out_count), 64'd1);
      chk("bp_next_sum",   64'(out_sum),   64'd100);
      drive_beat(32'd5, 1'b0, 1'b1, 0);
      chk("bp_next_final", 64'(out_sum), 64'd105);
      ack();
    end

    // Reset in the middle of a frame
    begin
      logic [3:0][31:0] d;
      drive_beat(32'd7, 1'b1, 1'b0, 0);
      drive_beat(32'd8, 1'b0, 1'b0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_valid", 64'(out_valid), 64'd0);
      chk("mrst_ready", 64'(in_ready),  64'd1);
      chk("mrst_sum",   64'(out_sum),   64'd0);
      chk("mrst_cout",  64'(out_cout),  64'd0);
      chk("mrst_count", 64'(out_count), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      d[0] = 9; d[1] = 1; d[2] = 1; d[3] = 1;
      run_frame("after_rst", d, 4'h0, 4, 1'b0, 0, 0, 32'd12, 1'b0, 4);
    end

    // Random frames checked against a running-sum model
    for (int f = 0; f < 40; f++) begin
      logic [3:0][31:0] d;
      logic [3:0]       cin;
      int               n;
      logic             ul;
      longint           r;
      logic             c;
      logic [31:0]      exp;
      n  = int'($urandom_range(1, BEATS));
      ul = (n < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      r = 0; c = 1'b0;
      for (int i = 0; i < 4; i++) begin
        d[i]   = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
        cin[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < n; i++) begin
        r = r + longint'(d[i]) + longint'(cin[i]);
        if (r >= 64'h1_0000_0000) begin c = 1'b1; r = r - 64'h1_0000_0000; end
      end
      exp = r[31:0];
`ifdef SATURATE_EN
      if (c) exp = 32'hFFFF_FFFF;
`endif
      run_frame($sformatf("rnd%0d", f), d, cin, n, ul, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), exp, c, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
